// File: rtl/heartbeat_sequencer_pkg.sv
// Shared types for the heartbeat sequencer.
//   u32          : 32-bit unsigned word used on the config port
//   step_t       : one pattern table entry (period, duty, last flag)
//   seq_state_e  : sequencer FSM states
//   clamp_period : limits a written period to the largest legal value
package heartbeat_sequencer_pkg;

    typedef logic [31:0] u32;

    typedef struct packed {
        u32   period;
        u32   duty;
        logic last;
    } step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    function automatic u32 clamp_period(input u32 period, input u32 max_period);
        return (period > max_period) ? max_period : period;
    endfunction

endpackage

// File: rtl/heartbeat_step_timer.sv
// Times one pattern step: frame up-counter from 0 to period-1, LED on while
// frame < duty.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : abort the step immediately (LED off)
//   load       : start a new step with period/duty
//   period     : step length in cycles (nonzero when load is asserted)
//   duty       : on-cycles at the start of the step
//   step_end   : high during the last frame of the step
//   on         : registered LED drive for the current frame
module heartbeat_step_timer
    import heartbeat_sequencer_pkg::*;
#(
    parameter int CW = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  u32   period,
    input  u32   duty,
    output logic step_end,
    output logic on
);

    logic [CW-1:0] frame;
    logic [CW-1:0] frame_inc;
    u32            period_r;
    u32            duty_r;
    logic          active;

    assign frame_inc = frame + CW'(1);
    assign step_end  = active && (u32'(frame) == period_r - 32'd1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            active   <= 1'b0;
            frame    <= '0;
            on       <= 1'b0;
            period_r <= '0;
            duty_r   <= '0;
        end else if (load) begin
            active   <= 1'b1;
            frame    <= '0;
            period_r <= period;
            duty_r   <= duty;
            on       <= (duty != 32'd0);
        end else if (active) begin
            if (step_end) begin
                active <= 1'b0;
                frame  <= '0;
                on     <= 1'b0;
            end else begin
                frame <= frame_inc;
                // 'on' is registered, so it is evaluated for the frame being entered.
                on    <= (u32'(frame_inc) < duty_r);
            end
        end
    end

endmodule

// File: rtl/heartbeat_sequencer.sv
// Programmable blink pattern player for status/fault LED codes.
// Owns the pattern table, the sequencing FSM and the pass counter; one
// heartbeat_step_timer times the active step.
//   clk, reset          : system clock, synchronous active-high reset
//   cfg_we/addr/period/duty/last : table write port (ignored while busy)
//   start, stop         : begin / abort pattern (pulses; stop wins)
//   repeat_count        : passes to play, 0 = forever
//   busy                : pattern active (LOAD or RUN)
//   done                : one-cycle pulse on normal completion
//   step_idx            : current table index
//   o_heartbeat         : LED drive
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | one cycle reading entry[step_idx], LED off
// RUN   | step timer running, LED follows duty
// DONE  | one-cycle completion pulse, LED off
module heartbeat_sequencer
    import heartbeat_sequencer_pkg::*;
#(
    parameter int STEPS      = 8,
    parameter int MAX_PERIOD = 12_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [$clog2(STEPS)-1:0] cfg_addr,
    input  u32                       cfg_period,
    input  u32                       cfg_duty,
    input  logic                     cfg_last,
    input  logic                     start,
    input  logic                     stop,
    input  logic [7:0]               repeat_count,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     o_heartbeat
);

    localparam int IW    = $clog2(STEPS);
    localparam int CW    = $clog2(MAX_PERIOD + 1);
    localparam u32 MAX_P = u32'(MAX_PERIOD);

    step_t      table_mem [STEPS];
    step_t      cur;
    seq_state_e state;
    logic [7:0] pass;
    logic [7:0] reps;
    logic [8:0] pass_next;
    logic [7:0] pass_sat;
    logic       step_end;
    logic       timer_load;

    // Table has no reset: contents survive a reset so a restart replays them.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            table_mem[cfg_addr].period <= clamp_period(cfg_period, MAX_P);
            table_mem[cfg_addr].duty   <= cfg_duty;
            table_mem[cfg_addr].last   <= cfg_last;
        end
    end

    assign cur        = table_mem[step_idx];
    assign pass_next  = {1'b0, pass} + 9'd1;
    // Saturate in forever mode so the count can never wrap onto a stop value.
    assign pass_sat   = (pass == 8'hFF) ? pass : pass_next[7:0];
    assign timer_load = (state == LOAD) && !stop && (cur.period != 32'd0);

    heartbeat_step_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (stop),
        .load     (timer_load),
        .period   (cur.period),
        .duty     (cur.duty),
        .step_end (step_end),
        .on       (o_heartbeat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_idx <= '0;
            pass     <= '0;
            reps     <= '0;
        end else if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        reps     <= repeat_count;
                        step_idx <= '0;
                        pass     <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (cur.period == 32'd0) begin
                        // Zero period terminates the pattern; at index 0 it is an empty pass.
                        if (step_idx == '0) pass <= pass_sat;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (step_end) begin
                        if (!cur.last && (step_idx != IW'(STEPS - 1))) begin
                            step_idx <= step_idx + IW'(1);
                            state    <= LOAD;
                        end else begin
                            pass <= pass_sat;
                            if ((reps != 8'd0) && (pass_next == {1'b0, reps})) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                step_idx <= '0;
                                state    <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heartbeat_sequencer.sv
// Directed test of heartbeat_sequencer: pattern timing, step sequencing,
// empty pattern, forever mode with stop, dropped writes, reset mid-run.
module tb_heartbeat_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_duty = '0;
    logic        cfg_last = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  repeat_count = '0;
    logic        busy;
    logic        done;
    logic [2:0]  step_idx;
    logic        o_heartbeat;

    int n_chk = 0;
    int n_fail = 0;

    heartbeat_sequencer #(.STEPS(8), .MAX_PERIOD(12_000_000)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_last     (cfg_last),
        .start        (start),
        .stop         (stop),
        .repeat_count (repeat_count),
        .busy         (busy),
        .done         (done),
        .step_idx     (step_idx),
        .o_heartbeat  (o_heartbeat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input int period, input int duty, input bit last);
        cfg_we     = 1'b1;
        cfg_addr   = 3'(addr);
        cfg_period = 32'(period);
        cfg_duty   = 32'(duty);
        cfg_last   = last;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input int rep);
        repeat_count = 8'(rep);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in a LOAD cycle; walks the step's RUN frames and leaves on the following cycle.
    task automatic check_step(input int idx, input int period, input int duty);
        chk("load_hb", 32'(o_heartbeat), 0);
        chk("load_busy", 32'(busy), 1);
        chk("load_idx", 32'(step_idx), 32'(idx));
        for (int f = 0; f < period; f++) begin
            tick();
            chk("run_hb", 32'(o_heartbeat), (f < duty) ? 32'd1 : 32'd0);
            chk("run_idx", 32'(step_idx), 32'(idx));
            chk("run_busy", 32'(busy), 1);
            chk("run_done", 32'(done), 0);
        end
        tick();
    endtask

    task automatic check_done_pulse();
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_hb", 32'(o_heartbeat), 0);
        tick();
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int dones;

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_idx", 32'(step_idx), 0);
        chk("rst_hb", 32'(o_heartbeat), 0);
        reset = 1'b0;
        tick();

        // 1: single step 3 on / 7 off, two passes
        wr(0, 10, 3, 1'b1);
        go(2);
        check_step(0, 10, 3);
        check_step(0, 10, 3);
        check_done_pulse();

        // 2: three-step pattern, single pass
        wr(0, 4, 1, 1'b0);
        wr(1, 6, 6, 1'b0);
        wr(2, 5, 0, 1'b1);
        go(1);
        check_step(0, 4, 1);
        check_step(1, 6, 6);
        check_step(2, 5, 0);
        check_done_pulse();

        // 3: empty pattern
        wr(0, 0, 5, 1'b0);
        go(1);
        chk("empty_load_hb", 32'(o_heartbeat), 0);
        chk("empty_load_busy", 32'(busy), 1);
        tick();
        check_done_pulse();

        // 4: forever mode, 8 entries without last, wrap 7->0, then stop
        for (int i = 0; i < 8; i++) wr(i, 1, 1, 1'b0);
        go(0);
        for (int i = 0; i < 8; i++) check_step(i, 1, 1);
        check_step(0, 1, 1);
        dones = 0;
        for (int c = 0; c < 300 * 16; c++) begin
            tick();
            if (done) dones++;
        end
        chk("forever_no_done", 32'(dones), 0);
        chk("forever_busy", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_hb", 32'(o_heartbeat), 0);
        chk("stop_done", 32'(done), 0);
        tick();
        chk("stop_done2", 32'(done), 0);
        chk("stop_busy2", 32'(busy), 0);

        // 5: writes and start during RUN ignored; start+stop in IDLE stays IDLE
        wr(0, 4, 2, 1'b1);
        go(1);
        tick();
        chk("wr_run_f0", 32'(o_heartbeat), 1);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_period = 32'd8; cfg_duty = 32'd8; cfg_last = 1'b1;
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        start = 1'b0;
        chk("wr_run_f1", 32'(o_heartbeat), 1);
        tick();
        chk("wr_run_f2", 32'(o_heartbeat), 0);
        tick();
        chk("wr_run_f3", 32'(o_heartbeat), 0);
        tick();
        check_done_pulse();
        go(1);
        check_step(0, 4, 2);
        check_done_pulse();
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", 32'(busy), 0);
        tick();
        chk("startstop_busy2", 32'(busy), 0);
        chk("startstop_hb", 32'(o_heartbeat), 0);

        // 6: reset mid-RUN, then replay the preserved table
        go(1);
        tick();
        chk("pre_rst_hb", 32'(o_heartbeat), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_hb", 32'(o_heartbeat), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_idx", 32'(step_idx), 0);
        chk("mid_rst_done", 32'(done), 0);
        go(1);
        check_step(0, 4, 2);
        check_done_pulse();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
